// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with in-order response buffer and redirect drain
// Issues word-aligned fetches, buffers {data, pc} per response, and discards stale responses after a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_pc;
    logic [31:0]     r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_outstanding_next;
    logic [CW-1:0]   w_discard_next;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [31:0]     r_buf_data [DEPTH];
    logic [31:0]     r_buf_pc   [DEPTH];

    logic            w_accept;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic [CW:0]     w_occ;
    logic [31:0]     w_redirect_pc;

    assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_occ         = {1'b0, r_count} + {1'b0, r_outstanding};

    // Occupancy counts in-flight requests so every response is guaranteed a buffer slot.
    assign o_imem_req_valid = !i_rst && (r_state == FETCH) && !i_redirect
                              && (w_occ < (CW+1)'(DEPTH));
    assign o_imem_req_addr  = r_pc;

    assign w_accept = o_imem_req_valid && i_imem_req_ready;
    assign w_rsp    = i_imem_rsp_valid && (r_outstanding != '0);
    assign w_push   = w_rsp && (r_state == FETCH) && !i_redirect;
    assign w_pop    = o_valid && i_ready;

    assign o_valid       = (r_count != '0);
    assign o_instruction = o_valid ? r_buf_data[r_rd_ptr] : NOP;
    assign o_pc          = o_valid ? r_buf_pc[r_rd_ptr]   : 32'h0000_0000;

    always_comb begin
        w_state_next       = r_state;
        w_discard_next     = r_discard;
        w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(w_rsp);
        if (i_redirect) begin
            w_discard_next = r_outstanding - CW'(w_rsp);
            w_state_next   = (w_discard_next != '0) ? DRAIN : FETCH;
        end else if ((r_state == DRAIN) && w_rsp && (r_discard != '0)) begin
            w_discard_next = r_discard - CW'(1);
            if (r_discard == CW'(1)) begin
                w_state_next = FETCH;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;
            if (i_redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            // Responses return in order, so the next kept response belongs to r_rsp_pc.
            if (i_redirect) begin
                r_rsp_pc <= w_redirect_pc;
            end else if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_redirect) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_data[r_wr_ptr] <= i_imem_rsp_data;
            r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel4 = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        v2, v4, rv2, rv4;
    logic [31:0] ins2, ins4, pc2, pc4, ad2, ad4;
    logic        m_valid, m_req_valid;
    logic [31:0] m_ins, m_pc, m_req_addr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst | sel4),
        .o_imem_req_valid(rv2), .o_imem_req_addr(ad2), .i_imem_req_ready(req_ready),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .o_valid(v2), .o_instruction(ins2), .o_pc(pc2), .i_ready(ready),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst | !sel4),
        .o_imem_req_valid(rv4), .o_imem_req_addr(ad4), .i_imem_req_ready(req_ready),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .o_valid(v4), .o_instruction(ins4), .o_pc(pc4), .i_ready(ready),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc)
    );

    assign m_valid     = sel4 ? v4   : v2;
    assign m_ins       = sel4 ? ins4 : ins2;
    assign m_pc        = sel4 ? pc4  : pc2;
    assign m_req_valid = sel4 ? rv4  : rv2;
    assign m_req_addr  = sel4 ? ad4  : ad2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    logic [7:0] tag = 8'h11;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t q[$];

    logic        lg_v   [64];
    logic [31:0] lg_pc  [64];
    logic [31:0] lg_ins [64];
    logic        lg_rv  [64];
    logic        lg_acc [64];
    logic [31:0] lg_addr[64];
    logic        lg_rsp [64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {tag, 24'h00_0013};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic run_cycle();
        rsp_t e;
        if (cyc < 64) begin
            lg_v[cyc]   = m_valid;
            lg_pc[cyc]  = m_pc;
            lg_ins[cyc] = m_ins;
        end
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = e.data;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        #1;
        if (cyc < 64) begin
            lg_rv[cyc]   = m_req_valid;
            lg_acc[cyc]  = m_req_valid && req_ready;
            lg_addr[cyc] = m_req_addr;
            lg_rsp[cyc]  = rsp_valid;
        end
        if (m_req_valid && req_ready) begin
            e.data = mem_word(m_req_addr);
            e.due  = cyc + lat;
            q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic use4);
        rst = 1'b1;
        sel4 = use4;
        q.delete();
        ready = 1'b0;
        redirect = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        tag = tag + 8'h01;
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [31:0] b2w(input logic b);
        return {31'b0, b};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int nv;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", b2w(m_valid), 32'd0);
        check_eq("rst_instr", m_ins, 32'h0000_0013);
        check_eq("rst_pc", m_pc, 32'd0);
        check_eq("rst_req_valid", b2w(m_req_valid), 32'd0);

        // Latency 1, always ready, DEPTH=4: back-to-back fetch stream.
        do_reset(1'b1);
        lat = 1; ready = 1'b1; req_ready = 1'b1;
        repeat (6) run_cycle();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("stream_acc%0d", i), b2w(lg_acc[i]), 32'd1);
            check_eq($sformatf("stream_addr%0d", i), lg_addr[i], 32'(4 * i));
            check_eq($sformatf("stream_valid%0d", i), b2w(lg_v[i + 2]), 32'd1);
            check_eq($sformatf("stream_pc%0d", i), lg_pc[i + 2], 32'(4 * i));
            check_eq($sformatf("stream_ins%0d", i), lg_ins[i + 2], mem_word(32'(4 * i)));
        end
        check_eq("no_bypass", b2w(lg_v[1]), 32'd0);

        // DEPTH=2, decode stalled: two requests then hold.
        do_reset(1'b0);
        lat = 1; ready = 1'b0; req_ready = 1'b1;
        repeat (6) run_cycle();
        check_eq("first_req_valid", b2w(lg_rv[0]), 32'd1);
        check_eq("first_req_addr", lg_addr[0], 32'h0);
        check_eq("stall_addr1", lg_addr[1], 32'h4);
        nv = 0;
        for (int i = 0; i < 6; i++) nv += int'(lg_acc[i]);
        check_eq("stall_req_count", 32'(nv), 32'd2);
        check_eq("stall_req_off", b2w(lg_rv[5]), 32'd0);
        check_eq("stall_hold_valid", b2w(lg_v[5]), 32'd1);
        check_eq("stall_hold_pc", lg_pc[5], 32'h0);
        ready = 1'b1;
        repeat (2) run_cycle();
        check_eq("release_pc0", lg_pc[6], 32'h0);
        check_eq("release_pc1", lg_pc[7], 32'h4);

        // Redirect alignment, then wrap of the fetch PC.
        do_reset(1'b0);
        lat = 1; ready = 1'b1; req_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        run_cycle();
        redirect = 1'b0;
        repeat (2) run_cycle();
        check_eq("redir_gate", b2w(lg_rv[0]), 32'd0);
        check_eq("redir_align", lg_addr[1], 32'h0000_0200);
        check_eq("redir_align_acc", b2w(lg_acc[1]), 32'd1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        run_cycle();
        redirect = 1'b0;
        repeat (3) run_cycle();
        check_eq("wrap_pre_pc", lg_pc[3], 32'h0000_0200);
        check_eq("wrap_flush", b2w(lg_v[4]), 32'd0);
        check_eq("wrap_addr0", lg_addr[4], 32'hFFFF_FFFC);
        check_eq("wrap_addr1", lg_addr[5], 32'h0);
        check_eq("wrap_acc1", b2w(lg_acc[5]), 32'd1);
        check_eq("wrap_pc", lg_pc[6], 32'hFFFF_FFFC);

        // Latency 3, redirect with two outstanding: drain both.
        do_reset(1'b0);
        lat = 3; ready = 1'b1; req_ready = 1'b1;
        repeat (2) run_cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        run_cycle();
        redirect = 1'b0;
        repeat (8) run_cycle();
        check_eq("drain_addr1", lg_addr[1], 32'h4);
        nv = 0;
        for (int i = 0; i < 9; i++) nv += int'(lg_v[i]);
        check_eq("drain_no_stale", 32'(nv), 32'd0);
        check_eq("drain_req_off3", b2w(lg_rv[3]), 32'd0);
        check_eq("drain_req_off4", b2w(lg_rv[4]), 32'd0);
        check_eq("drain_next_acc", b2w(lg_acc[5]), 32'd1);
        check_eq("drain_next_addr", lg_addr[5], 32'h0000_0100);
        check_eq("drain_out_pc", lg_pc[9], 32'h0000_0100);
        check_eq("drain_out_ins", lg_ins[9], mem_word(32'h0000_0100));

        // Redirect coinciding with handshake at pc 8 and a response.
        do_reset(1'b0);
        lat = 2; ready = 1'b1; req_ready = 1'b1;
        repeat (7) run_cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        run_cycle();
        redirect = 1'b0;
        repeat (4) run_cycle();
        check_eq("coinc_valid", b2w(lg_v[7]), 32'd1);
        check_eq("coinc_pc", lg_pc[7], 32'h8);
        check_eq("coinc_rsp", b2w(lg_rsp[7]), 32'd1);
        check_eq("coinc_empty", b2w(lg_v[8]), 32'd0);
        check_eq("coinc_next_addr", lg_addr[8], 32'h0000_0040);
        check_eq("coinc_next_pc", lg_pc[11], 32'h0000_0040);
        check_eq("coinc_next_ins", lg_ins[11], mem_word(32'h0000_0040));

        // Reset mid-flight; stale responses after release are ignored.
        do_reset(1'b0);
        lat = 3; ready = 1'b1; req_ready = 1'b1;
        repeat (2) run_cycle();
        rst = 1'b1;
        #1;
        check_eq("async_rst_addr", m_req_addr, 32'h0);
        check_eq("async_rst_req", b2w(m_req_valid), 32'd0);
        run_cycle();
        rst = 1'b0;
        tag = tag + 8'h01;
        req_ready = 1'b0;
        repeat (2) run_cycle();
        req_ready = 1'b1;
        repeat (5) run_cycle();
        check_eq("post_rst_req", b2w(lg_rv[3]), 32'd1);
        check_eq("post_rst_addr", lg_addr[3], 32'h0);
        check_eq("stale_rsp_seen", b2w(lg_rsp[4]), 32'd1);
        nv = 0;
        for (int i = 3; i < 9; i++) nv += int'(lg_v[i]);
        check_eq("stale_ignored", 32'(nv), 32'd0);
        check_eq("post_rst_pc", lg_pc[9], 32'h0);
        check_eq("post_rst_valid", b2w(lg_v[9]), 32'd1);
        check_eq("post_rst_ins", lg_ins[9], mem_word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
